// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage data port: FSM state type and default timeout.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/dmem_timer.sv
// Wait-cycle counter for an outstanding RAM request; flags the increment that reaches TIMEOUT.
module dmem_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;
    logic [CW:0]   w_next;

    assign w_next = {1'b0, r_count} + {{CW{1'b0}}, 1'b1};
    // High in the cycle whose increment lands the count on TIMEOUT, so the port can leave REQ on that edge.
    assign o_expired = i_inc && (w_next == (CW+1)'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= w_next[CW-1:0];
        end
    end

endmodule

// File: rtl/dmem_port.sv
// Memory-stage data port: ready/valid access to a variable-latency RAM with pipeline stall,
// load-data return and sticky misalign/timeout flags.
module dmem_port
    import mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memreadM,
    input  logic          memwriteM,
    input  logic [AW-1:0] addrM,
    input  logic [DW-1:0] writedataM,
    output logic [DW-1:0] readdataM,
    output logic          stallM,
    output logic          misalignM,
    output logic          timeoutM,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [1:0]    o_dbg_state
);

    state_t        r_state;
    state_t        w_next_state;
    logic          w_access;
    logic          w_aligned;
    logic          w_start;
    logic          w_timer_clr;
    logic          w_timer_inc;
    logic          w_expired;
    logic [DW-1:0] r_readdata;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_misalign;
    logic          r_timeout;

    assign w_access  = memreadM | memwriteM;
    assign w_aligned = (addrM[1:0] == 2'b00);
    assign w_start   = (r_state == IDLE) && w_access && w_aligned;

    dmem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clr     (w_timer_clr),
        .i_inc     (w_timer_inc),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next_state = r_state;
        w_timer_clr  = 1'b0;
        w_timer_inc  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next_state = REQ;
                    w_timer_clr  = 1'b1;
                end
            end
            REQ: begin
                if (mem_ready) begin
                    w_next_state = DONE;
                end else begin
                    w_timer_inc = 1'b1;
                    if (w_expired) begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // r_mem_we stays high for the whole REQ window, so it doubles as the load/store marker.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_readdata  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_misalign  <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && w_access && !w_aligned) begin
                r_misalign <= 1'b1;
            end
            if (w_start) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= memwriteM;
                r_mem_addr  <= {addrM[AW-1:2], 2'b00};
                r_mem_wdata <= writedataM;
            end
            if (r_state == REQ) begin
                if (mem_ready) begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    if (!r_mem_we) begin
                        r_readdata <= mem_rdata;
                    end
                end else if (w_expired) begin
                    r_mem_req <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_timeout <= 1'b1;
                    if (!r_mem_we) begin
                        r_readdata <= '0;
                    end
                end
            end
        end
    end

    assign stallM      = reset && (w_start || (r_state == REQ));
    assign readdataM   = r_readdata;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign misalignM   = r_misalign;
    assign timeoutM    = r_timeout;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_port.sv
// Directed plus randomized checks of dmem_port against a cycle-count reference model.
module tb_dmem_port;
  import mem_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadM;
  logic        memwriteM;
  logic [31:0] addrM;
  logic [31:0] writedataM;
  logic [31:0] readdataM;
  logic        stallM;
  logic        misalignM;
  logic        timeoutM;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  logic [31:0] exp_rd;
  logic        exp_mis;
  logic        exp_to;

  dmem_port #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .memreadM    (memreadM),
    .memwriteM   (memwriteM),
    .addrM       (addrM),
    .writedataM  (writedataM),
    .readdataM   (readdataM),
    .stallM      (stallM),
    .misalignM   (misalignM),
    .timeoutM    (timeoutM),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .o_dbg_state (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One instruction in M; the RAM answers in the (nwait+1)th request cycle, never if nwait >= TO.
  task automatic access(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int nwait, input logic [31:0] rdata);
    bit aligned;
    bit to;
    bit done;
    int stall_n;
    int req_n;
    int we_n;
    int unstable;
    int exp_req;
    int exp_stall;
    logic [31:0] a0;
    logic [31:0] d0;
    aligned = (addr[1:0] == 2'b00);
    to = (nwait >= TO);
    done = 1'b0;
    stall_n = 0;
    req_n = 0;
    we_n = 0;
    unstable = 0;
    a0 = '0;
    d0 = '0;
    memreadM = rd;
    memwriteM = wr;
    addrM = addr;
    writedataM = wdata;
    mem_rdata = rdata;
    mem_ready = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("first_cycle_stall", stallM, aligned);
      if (stallM) stall_n++;
      if (mem_req) begin
        req_n++;
        if (mem_we) we_n++;
        if (req_n == 1) begin
          a0 = mem_addr;
          d0 = mem_wdata;
        end else if (mem_addr !== a0 || mem_wdata !== d0) begin
          unstable++;
        end
      end
      mem_ready = mem_req && !to && (req_n == nwait + 1);
      if (!stallM) done = 1'b1;
    end
    mem_ready = 1'b0;
    chk("cycle_budget", done, 1'b1);
    exp_req = !aligned ? 0 : (to ? TO : nwait + 1);
    exp_stall = !aligned ? 0 : exp_req + 1;
    if (aligned) begin
      if (!wr) exp_rd = to ? 32'h0 : rdata;
      if (to) exp_to = 1'b1;
    end
    chk("stall_cycles", stall_n, exp_stall);
    chk("req_cycles", req_n, exp_req);
    chk("we_cycles", we_n, wr ? exp_req : 0);
    chk("req_addr_data_stable", unstable, 0);
    if (aligned) begin
      chk("req_addr", a0, addr);
      chk("req_wdata", d0, wdata);
    end
    chk("done_readdata", readdataM, exp_rd);
    chk("done_timeout_flag", timeoutM, exp_to);
    chk("done_req_low", mem_req, 1'b0);
    @(posedge clk);
    #1;
    memreadM = 1'b0;
    memwriteM = 1'b0;
    if (!aligned) exp_mis = 1'b1;
    chk("misalign_flag", misalignM, exp_mis);
    chk("back_in_idle", o_dbg_state, 32'(IDLE));
  endtask

  initial begin
    reset = 1'b0;
    memreadM = 1'b0;
    memwriteM = 1'b0;
    addrM = '0;
    writedataM = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;
    exp_rd = '0;
    exp_mis = 1'b0;
    exp_to = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_readdata", readdataM, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_flags", {misalignM, timeoutM}, 0);
    chk("rst_state", o_dbg_state, 32'(IDLE));
    memreadM = 1'b1;
    #1;
    chk("rst_stall_forced_low", stallM, 0);
    memreadM = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;

    // aligned load, zero wait
    access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    // aligned store, three wait cycles
    access(1'b0, 1'b1, 32'h24, 32'h12345678, 3, 32'hCAFEF00D);
    // misaligned load, flag must persist
    access(1'b1, 1'b0, 32'h13, 32'h0, 0, 32'h55555555);
    repeat (10) @(negedge clk);
    chk("misalign_sticky", misalignM, 1'b1);
    chk("misalign_no_req", mem_req, 1'b0);
    @(posedge clk);
    #1;
    // timeout on a load
    access(1'b1, 1'b0, 32'h30, 32'h0, 99, 32'hFFFFFFFF);

    // reset pulse during the second request cycle
    memreadM = 1'b1;
    addrM = 32'h40;
    mem_ready = 1'b0;
    mem_rdata = 32'hBADBAD00;
    repeat (3) @(negedge clk);
    chk("pre_reset_req", mem_req, 1'b1);
    reset = 1'b0;
    #1;
    chk("stall_low_in_reset", stallM, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    memreadM = 1'b0;
    exp_rd = '0;
    exp_mis = 1'b0;
    exp_to = 1'b0;
    @(negedge clk);
    chk("midreq_rst_outputs", {readdataM, mem_addr}, 0);
    chk("midreq_rst_ctrl", {mem_req, mem_we, misalignM, timeoutM, stallM}, 0);
    chk("midreq_rst_wdata", mem_wdata, 0);
    chk("midreq_rst_state", o_dbg_state, 32'(IDLE));
    mem_ready = 1'b1;
    @(negedge clk);
    chk("late_ready_readdata", readdataM, 0);
    chk("late_ready_req", mem_req, 0);
    chk("late_ready_state", o_dbg_state, 32'(IDLE));
    mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // back-to-back loads; first_cycle_stall of the second proves a single free cycle
    access(1'b1, 1'b0, 32'h0, 32'h0, 0, 32'h11111111);
    access(1'b1, 1'b0, 32'h4, 32'h0, 0, 32'h22222222);

    // randomized traffic
    for (int i = 0; i < 16; i++) begin
      int kind;
      int nw;
      logic [31:0] a;
      kind = $urandom_range(0, 2);
      a = $urandom & 32'h0000FFFC;
      if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
      nw = ($urandom_range(0, 6) == 0) ? TO + 1 : $urandom_range(0, 3);
      access(kind != 1, kind != 0, a, $urandom, nw, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
